// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM read arbiter: FSM state encoding,
// width helpers for the counter and round-robin pointer, and a one-hot decoder.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MAX_REQ = 8;
    localparam int MAX_LAT = 4;
    localparam int IDX_W   = $clog2(MAX_REQ);

    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin winner select: first set request bit scanning
// upward from ptr, wrapping modulo NUM_REQ.
module rr_priority_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               any,
    output logic [PTR_W-1:0]   w
);

    // Scan from the farthest candidate back to ptr so the nearest hit wins last.
    always_comb begin
        any = 1'b0;
        w   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                any = 1'b1;
                w   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM between NUM_REQ clients;
// one access in flight, one-cycle gnt pulse, one-cycle registered response.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int CNT_W = cnt_width(ROM_LAT);

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;

    logic               any;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] owner_oh;
    logic [ADDR_W-1:0]  win_addr;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .any (any),
        .w   (win)
    );

    assign win_oh   = NUM_REQ'(onehot(IDX_W'(win)));
    assign owner_oh = NUM_REQ'(onehot(IDX_W'(owner)));
    assign win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
    assign next_ptr = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            cnt       <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
        end else begin
            gnt       <= '0;
            rom_en    <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt      <= win_oh;
                        rom_en   <= 1'b1;
                        rom_addr <= win_addr;
                        owner    <= win;
                        cnt      <= CNT_W'(ROM_LAT);
                        rr_ptr   <= next_ptr;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // The first WAIT cycle is the enable cycle itself; the ROM
                    // latency is counted from the cycle after it.
                    if (!rom_en) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            rsp_data  <= rom_data;
                            rsp_valid <= owner_oh;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: a ROM_LAT=1 instance with a response scoreboard
// and a ROM_LAT=3 instance for latency checks, both backed by mem[a]=~a ROMs.
module tb_rom_read_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    // Instance A: ROM_LAT = 1
    logic [1:0] req_a = 2'b00;
    logic [7:0] req_addr_a = 8'h00;
    logic [1:0] gnt_a, rsp_valid_a;
    logic [3:0] rsp_data_a, rom_addr_a, rom_data_a;
    logic       busy_a, rom_en_a;

    rom_read_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(4), .ROM_LAT(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req       (req_a),
        .req_addr  (req_addr_a),
        .gnt       (gnt_a),
        .rsp_valid (rsp_valid_a),
        .rsp_data  (rsp_data_a),
        .busy      (busy_a),
        .rom_en    (rom_en_a),
        .rom_addr  (rom_addr_a),
        .rom_data  (rom_data_a)
    );

    initial rom_data_a = 4'h0;
    always @(posedge clk) if (rom_en_a) rom_data_a <= ~rom_addr_a;

    // Instance B: ROM_LAT = 3
    logic [1:0] req_b = 2'b00;
    logic [7:0] req_addr_b = 8'h00;
    logic [1:0] gnt_b, rsp_valid_b;
    logic [3:0] rsp_data_b, rom_addr_b, rom_data_b;
    logic       busy_b, rom_en_b;
    logic [3:0] pipe_b[3];

    rom_read_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(4), .ROM_LAT(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req_b),
        .req_addr  (req_addr_b),
        .gnt       (gnt_b),
        .rsp_valid (rsp_valid_b),
        .rsp_data  (rsp_data_b),
        .busy      (busy_b),
        .rom_en    (rom_en_b),
        .rom_addr  (rom_addr_b),
        .rom_data  (rom_data_b)
    );

    initial begin
        pipe_b[0] = 4'h0;
        pipe_b[1] = 4'h0;
        pipe_b[2] = 4'h0;
    end
    always @(posedge clk) begin
        if (rom_en_b) pipe_b[0] <= ~rom_addr_b;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rom_data_b = pipe_b[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every response strobe on instance A must match the queue head.
    always @(negedge clk) begin
        if (!rst && rsp_valid_a !== 2'b00) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid_a), 32'h0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("rsp_valid", 32'(rsp_valid_a), 32'(e[5:4]));
                check("rsp_data", 32'(rsp_data_a), 32'(e[3:0]));
            end
        end
    end

    initial begin
        logic [1:0] exp_g;

        // 1: reset holds everything quiet even with both requests up
        req_a = 2'b11;
        req_addr_a = {4'h7, 4'h6};
        repeat (3) tick();
        check("rst_gnt", 32'(gnt_a), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid_a), 32'h0);
        check("rst_rom_en", 32'(rom_en_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_rom_addr", 32'(rom_addr_a), 32'h0);
        check("rst_rsp_data", 32'(rsp_data_a), 32'h0);
        check("rst_rom_en_b", 32'(rom_en_b), 32'h0);

        // 3: both requesting from rr_ptr=0 -> 01, 10, 01 every 4 cycles
        exp_q.push_back({2'b01, 4'h9});
        exp_q.push_back({2'b10, 4'h8});
        exp_q.push_back({2'b01, 4'h9});
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_g = (k == 1 || k == 9) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
            check($sformatf("rr_gnt_c%0d", k), 32'(gnt_a), 32'(exp_g));
            if (k == 9) req_a = 2'b00;
        end
        repeat (3) tick();

        // 2: single request, latency and address check
        req_a = 2'b01;
        req_addr_a = {4'h0, 4'hE};
        exp_q.push_back({2'b01, 4'h1});
        tick();
        check("single_gnt", 32'(gnt_a), 32'h1);
        check("single_rom_en", 32'(rom_en_a), 32'h1);
        check("single_rom_addr", 32'(rom_addr_a), 32'hE);
        check("single_busy", 32'(busy_a), 32'h1);
        req_a = 2'b00;
        tick();
        check("single_gnt_pulse", 32'(gnt_a), 32'h0);
        check("single_rom_en_pulse", 32'(rom_en_a), 32'h0);
        check("single_rom_addr_hold", 32'(rom_addr_a), 32'hE);
        tick();
        check("single_rsp_valid", 32'(rsp_valid_a), 32'h1);
        check("single_rsp_data", 32'(rsp_data_a), 32'h1);
        tick();
        check("single_rsp_pulse", 32'(rsp_valid_a), 32'h0);
        check("single_rsp_hold", 32'(rsp_data_a), 32'h1);
        check("single_idle_busy", 32'(busy_a), 32'h0);

        // 4: req0 raised while busy and withdrawn before the arbiter is back in IDLE
        req_a = 2'b10;
        req_addr_a = {4'h0, 4'h0};
        exp_q.push_back({2'b10, 4'hF});
        tick();
        check("wd_gnt1", 32'(gnt_a), 32'h2);
        req_a = 2'b00;
        tick();
        req_a = 2'b01;
        req_addr_a = {4'h0, 4'h3};
        tick();
        req_a = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("wd_gnt_c%0d", k), 32'(gnt_a), 32'h0);
            check($sformatf("wd_busy_c%0d", k), 32'(busy_a), 32'h0);
        end

        // 5: reset during WAIT drops the access
        req_a = 2'b01;
        req_addr_a = {4'h0, 4'h3};
        tick();
        check("rw_gnt", 32'(gnt_a), 32'h1);
        req_a = 2'b00;
        rst = 1'b1;
        tick();
        check("rw_gnt_clr", 32'(gnt_a), 32'h0);
        check("rw_rom_en_clr", 32'(rom_en_a), 32'h0);
        check("rw_rsp_valid_clr", 32'(rsp_valid_a), 32'h0);
        check("rw_busy_clr", 32'(busy_a), 32'h0);
        check("rw_rom_addr_clr", 32'(rom_addr_a), 32'h0);
        check("rw_rsp_data_clr", 32'(rsp_data_a), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rw_no_rsp_c%0d", k), 32'(rsp_valid_a), 32'h0);
        end
        req_a = 2'b10;
        req_addr_a = {4'h5, 4'h0};
        exp_q.push_back({2'b10, 4'hA});
        tick();
        check("rw_new_gnt", 32'(gnt_a), 32'h2);
        req_a = 2'b00;
        repeat (4) tick();

        // 6: ROM_LAT=3 instance
        req_b = 2'b01;
        req_addr_b = {4'h0, 4'h2};
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("lat3_rom_en_c%0d", k), 32'(rom_en_b), (k == 1) ? 32'h1 : 32'h0);
            check($sformatf("lat3_rsp_valid_c%0d", k), 32'(rsp_valid_b), (k == 5) ? 32'h1 : 32'h0);
            if (k == 1) begin
                check("lat3_gnt", 32'(gnt_b), 32'h1);
                req_b = 2'b00;
            end
            if (k == 5) check("lat3_rsp_data", 32'(rsp_data_b), 32'hD);
        end

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
